// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the ID/EX pipeline boundary:
//   alu_op_e       ALU operation codes 4'b0000..4'b1011 (ADD..PASSB)
//   src_a_e/src_b_e operand-select encodings
//   ex_ctrl_t      registered control fields of the EX stage
//   EX_CTRL_BUBBLE the no-op control word loaded on reset, flush and bubbles
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSA = 4'b1010,
        ALU_PASSB = 4'b1011
    } alu_op_e;

    typedef enum logic {
        SRC_A_RS1 = 1'b0,
        SRC_A_PC  = 1'b1
    } src_a_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // alu_ctrl is a plain vector so undefined codes above ALU_PASSB pass through
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_ctrl;
        src_a_e     src_a;
        src_b_e     src_b;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        rd:        REG_X0,
        rs1:       REG_X0,
        rs2:       REG_X0,
        alu_ctrl:  ALU_ADD,
        src_a:     SRC_A_RS1,
        src_b:     SRC_B_RS2
    };

endpackage

// File: rtl/fwd_unit.sv
// ----------------------------------------------------------------------------
// fwd_unit
// Operand bypass for one EX source register. MEM result has priority over WB
// result; x0 is never bypassed.
//   i_rs                EX source register index
//   i_reg_data          value read from the register file at decode
//   i_mem_rd/_reg_write/_result   MEM-stage writeback candidate
//   i_wb_rd/_reg_write/_result    WB-stage writeback candidate
//   o_fwd               operand value after bypass
// ----------------------------------------------------------------------------
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [4:0]            i_rs,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    input  logic [4:0]            i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic [DATA_WIDTH-1:0] i_mem_result,
    input  logic [4:0]            i_wb_rd,
    input  logic                  i_wb_reg_write,
    input  logic [DATA_WIDTH-1:0] i_wb_result,
    output logic [DATA_WIDTH-1:0] o_fwd
);

    logic w_rs_nz;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_rs_nz   = (i_rs != REG_X0);
    assign w_hit_mem = w_rs_nz & i_mem_reg_write & (i_mem_rd == i_rs);
    assign w_hit_wb  = w_rs_nz & i_wb_reg_write  & (i_wb_rd  == i_rs);

    always_comb begin
        o_fwd = i_reg_data;
        if (w_hit_mem) begin
            o_fwd = i_mem_result;
        end else if (w_hit_wb) begin
            o_fwd = i_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and operand bypass.
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decoded instruction fields and controls
//   stall, flush               hold / kill requests (flush wins)
//   mem_*, wb_*                bypass sources from later stages
//   ALUop1, ALUop2, ALUctrl    ALU operands and operation
//   ex_store_data, ex_pc       bypassed rs2 for stores, instruction PC
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd   EX controls
//   load_use                   combinational request to hold fetch/decode
// ----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            id_rd,
    input  logic [3:0]            id_alu_ctrl,
    input  logic                  id_src_a,
    input  logic                  id_src_b,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [4:0]            mem_rd,
    input  logic                  mem_reg_write,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [4:0]            wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [3:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [4:0]            ex_rd,
    output logic                  load_use
);

    ex_ctrl_t              r_ctrl;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_pc;

    ex_ctrl_t              w_id_ctrl;
    logic                  w_load_use;
    logic                  w_bubble;
    logic [DATA_WIDTH-1:0] w_fwd_rs1;
    logic [DATA_WIDTH-1:0] w_fwd_rs2;

    assign w_id_ctrl = '{
        valid:     id_valid,
        reg_write: id_reg_write,
        mem_read:  id_mem_read,
        mem_write: id_mem_write,
        rd:        id_rd,
        rs1:       id_rs1,
        rs2:       id_rs2,
        alu_ctrl:  id_alu_ctrl,
        src_a:     src_a_e'(id_src_a),
        src_b:     src_b_e'(id_src_b)
    };

    // rs2 only matters to the hazard when the ALU actually reads it; a store's
    // rs2 would also be exposed, but it is bypassed in EX from MEM one cycle later.
    assign w_load_use = r_ctrl.valid & r_ctrl.mem_read & (r_ctrl.rd != REG_X0) & id_valid &
                        ((r_ctrl.rd == id_rs1) |
                         ((r_ctrl.rd == id_rs2) & (src_b_e'(id_src_b) == SRC_B_RS2)));

    // Flush overrides stall; a hazard or empty decode slot only bubbles when not held.
    assign w_bubble = flush | (~stall & (w_load_use | ~id_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= EX_CTRL_BUBBLE;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
        end else if (w_bubble) begin
            r_ctrl     <= EX_CTRL_BUBBLE;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
        end else if (!stall) begin
            r_ctrl     <= w_id_ctrl;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
        end
    end

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
        .i_rs            (r_ctrl.rs1),
        .i_reg_data      (r_rs1_data),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_fwd           (w_fwd_rs1)
    );

    fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
        .i_rs            (r_ctrl.rs2),
        .i_reg_data      (r_rs2_data),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_fwd           (w_fwd_rs2)
    );

    assign ALUop1        = (r_ctrl.src_a == SRC_A_PC)  ? r_pc  : w_fwd_rs1;
    assign ALUop2        = (r_ctrl.src_b == SRC_B_IMM) ? r_imm : w_fwd_rs2;
    assign ALUctrl       = r_ctrl.alu_ctrl;
    assign ex_store_data = w_fwd_rs2;
    assign ex_pc         = r_pc;
    assign ex_valid      = r_ctrl.valid;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_rd         = r_ctrl.rd;
    assign load_use      = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk, rst_n;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a, id_src_b, stall, flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] ALUop1, ALUop2, ex_store_data, ex_pc;
    logic [3:0]  ALUctrl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use;
    logic [4:0]  ex_rd;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    id_ex_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_src_a(id_src_a), .id_src_b(id_src_b),
        .stall(stall), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .load_use(load_use)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid, rw, mr, mw, sa, sb;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  ctrl;
        logic [31:0] d1, d2, imm, pc;
    } mex_t;

    mex_t m;

    function automatic mex_t bubble();
        mex_t b;
        b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.sa = 0; b.sb = 0;
        b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.ctrl = 0;
        b.d1 = 0; b.d2 = 0; b.imm = 0; b.pc = 0;
        return b;
    endfunction

    function automatic logic model_lu();
        return m.valid && m.mr && (m.rd != 0) && id_valid &&
               ((m.rd == id_rs1) || ((m.rd == id_rs2) && !id_src_b));
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] regv);
        if (r != 0 && mem_reg_write && mem_rd == r) return mem_result;
        if (r != 0 && wb_reg_write && wb_rd == r) return wb_result;
        return regv;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = bubble();
        end else begin
            if (flush) m = bubble();
            else if (stall) begin end
            else if (model_lu() || !id_valid) m = bubble();
            else begin
                m.valid = 1; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
                m.sa = id_src_a; m.sb = id_src_b; m.rd = id_rd; m.rs1 = id_rs1; m.rs2 = id_rs2;
                m.ctrl = id_alu_ctrl; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
                m.imm = id_imm; m.pc = id_pc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
            chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
            chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m.mw});
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
            chk("ALUctrl", {28'b0, ALUctrl}, {28'b0, m.ctrl});
            chk("load_use", {31'b0, load_use}, {31'b0, model_lu()});
            if (m.valid) begin
                chk("ALUop1", ALUop1, m.sa ? m.pc : model_fwd(m.rs1, m.d1));
                chk("ALUop2", ALUop2, m.sb ? m.imm : model_fwd(m.rs2, m.d2));
                chk("ex_store_data", ex_store_data, model_fwd(m.rs2, m.d2));
                chk("ex_pc", ex_pc, m.pc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_id(input logic v, rw, mr, mw, input logic [4:0] rs1, rs2, rd,
                            input logic [3:0] ctrl, input logic sa, sb,
                            input logic [31:0] d1, d2, imm, pc);
        id_valid = v; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_ctrl = ctrl;
        id_src_a = sa; id_src_b = sb;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    endtask

    task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_write = mrw; mem_rd = mrd; mem_result = mres;
        wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        m = bubble();
        repeat (2) step();
        chk("rst ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst ALUctrl", {28'b0, ALUctrl}, 32'd0);
        chk("rst load_use", {31'b0, load_use}, 32'd0);
        rst_n = 1;
        cmp_en = 1;

        // basic capture: imm operand
        drive_id(1, 1, 0, 0, 5'd1, 5'd2, 5'd3, 4'b0000, 0, 1, 32'd5, 32'd9, 32'd7, 32'h100);
        step();
        chk("cap ALUop1", ALUop1, 32'd5);
        chk("cap ALUop2", ALUop2, 32'd7);
        chk("cap ex_valid", {31'b0, ex_valid}, 32'd1);

        // forward priority on rs1
        drive_id(1, 1, 0, 0, 5'd3, 5'd2, 5'd4, 4'b0001, 0, 0, 32'h11, 32'h22, 0, 32'h104);
        step();
        set_fwd(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
        #1 chk("fwd mem wins", ALUop1, 32'hAA);
        mem_reg_write = 0;
        #1 chk("fwd wb", ALUop1, 32'hBB);
        drive_id(1, 1, 0, 0, 5'd0, 5'd2, 5'd4, 4'b0001, 0, 0, 32'h22, 32'h22, 0, 32'h108);
        step();
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        #1 chk("fwd x0", ALUop1, 32'h22);
        set_fwd(0, 0, 0, 0, 0, 0);

        // load-use: lw x5 then add x6,x5,x1
        drive_id(1, 1, 1, 0, 5'd2, 5'd0, 5'd5, 4'b0000, 0, 1, 32'h0, 0, 32'h10, 32'h10C);
        step();
        drive_id(1, 1, 0, 0, 5'd5, 5'd1, 5'd6, 4'b0000, 0, 0, 32'hDEAD, 32'h3, 0, 32'h110);
        #1 chk("lu set", {31'b0, load_use}, 32'd1);
        step();
        chk("lu bubble", {31'b0, ex_valid}, 32'd0);
        set_fwd(1, 5'd5, 32'h1234, 0, 0, 0);
        step();
        chk("lu add valid", {31'b0, ex_valid}, 32'd1);
        chk("lu add rd", {27'b0, ex_rd}, 32'd6);
        chk("lu add fwd", ALUop1, 32'h1234);
        set_fwd(0, 0, 0, 0, 0, 0);

        // flush with stall and load_use pending
        drive_id(1, 1, 1, 0, 5'd1, 5'd0, 5'd7, 4'b0000, 0, 1, 0, 0, 32'h4, 32'h114);
        step();
        drive_id(1, 1, 0, 0, 5'd7, 5'd7, 5'd8, 4'b0011, 0, 0, 1, 2, 0, 32'h118);
        stall = 1; flush = 1;
        #1 chk("fl lu", {31'b0, load_use}, 32'd1);
        step();
        chk("fl valid", {31'b0, ex_valid}, 32'd0);
        chk("fl rd", {27'b0, ex_rd}, 32'd0);
        chk("fl ALUctrl", {28'b0, ALUctrl}, 32'd0);
        stall = 0; flush = 0;

        // stall holds for three cycles; undefined ALU code passes through
        drive_id(1, 1, 0, 0, 5'd0, 5'd0, 5'd9, 4'hD, 0, 1, 32'h31, 0, 32'h41, 32'h11C);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1, $urandom_range(0, 1), 0, 0, 5'($urandom), 5'($urandom), 5'($urandom),
                     4'($urandom), 0, 0, $urandom, $urandom, $urandom, $urandom);
            step();
            chk("stall rd", {27'b0, ex_rd}, 32'd9);
            chk("stall ALUctrl", {28'b0, ALUctrl}, 32'hD);
            chk("stall op1", ALUop1, 32'h31);
            chk("stall op2", ALUop2, 32'h41);
        end
        stall = 0;

        // store: imm operand, rs2 bypassed from WB
        drive_id(1, 0, 0, 1, 5'd0, 5'd4, 5'd0, 4'b0000, 0, 1, 0, 32'h99, 32'd8, 32'h120);
        step();
        set_fwd(0, 5'd4, 32'h77, 1, 5'd4, 32'h55);
        #1 chk("st op2", ALUop2, 32'd8);
        chk("st data", ex_store_data, 32'h55);
        set_fwd(0, 0, 0, 0, 0, 0);

        // asynchronous reset mid-cycle during a stall
        drive_id(1, 1, 0, 0, 5'd1, 5'd2, 5'd11, 4'b0010, 0, 0, 32'h5, 32'h6, 0, 32'h124);
        step();
        stall = 1;
        #1 rst_n = 0;
        #1 chk("arst valid", {31'b0, ex_valid}, 32'd0);
        chk("arst rd", {27'b0, ex_rd}, 32'd0);
        chk("arst ALUctrl", {28'b0, ALUctrl}, 32'd0);
        chk("arst op1", ALUop1, 32'd0);
        chk("arst lu", {31'b0, load_use}, 32'd0);
        #1 rst_n = 1;
        stall = 0;
        drive_id(1, 1, 0, 0, 5'd1, 5'd2, 5'd12, 4'b0010, 0, 0, 32'h5, 32'h6, 0, 32'h128);
        step();
        chk("post-rst valid", {31'b0, ex_valid}, 32'd1);
        chk("post-rst rd", {27'b0, ex_rd}, 32'd12);

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            drive_id(($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                     1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, $urandom, $urandom, $urandom);
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
